// File: rtl/issue_rat_pkg.sv
// Shared widths, index types and walker state encoding for the issue-stage RAT free list.
package issue_rat_pkg;

    localparam int unsigned PrfCountDef    = 64;
    localparam int unsigned PrfReservedDef = 32;
    localparam int unsigned FgrCountDef    = 16;

    localparam int unsigned PW = $clog2(PrfCountDef);
    localparam int unsigned FW = $clog2(FgrCountDef);

    typedef logic [PW-1:0] prf_idx_t;
    typedef logic [FW-1:0] fgr_idx_t;

    typedef enum logic [0:0] {
        StIdle,
        StWalk
    } walk_state_e;

endpackage

// File: rtl/issue_rat_freelist_walk_fifo.sv
// Circular PRF free list: one pop, up to two pushes per cycle, preloaded with the unmapped PRFs.
module issue_rat_freelist_walk_fifo
    import issue_rat_pkg::*;
#(
    parameter int unsigned P_DEPTH    = PrfCountDef,
    parameter int unsigned P_RESERVED = PrfReservedDef,
    localparam int unsigned DW        = $clog2(P_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pop_i,
    input  logic          push_a_i,
    input  logic [DW-1:0] push_a_data_i,
    input  logic          push_b_i,
    input  logic [DW-1:0] push_b_data_i,
    output logic [DW-1:0] head_o,
    output logic [DW:0]   count_o
);

    localparam int unsigned InitCount = P_DEPTH - P_RESERVED;

    logic [DW-1:0] mem_q [P_DEPTH];
    logic [DW-1:0] rptr_q, rptr_d;
    logic [DW-1:0] wptr_q, wptr_d;
    logic [DW:0]   count_q, count_d;
    logic [DW-1:0] wptr_b;

    // Second push lands behind the first when both fire, otherwise it takes the write pointer.
    assign wptr_b = push_a_i ? wptr_q + DW'(1) : wptr_q;

    always_comb begin
        rptr_d  = rptr_q + DW'(pop_i);
        wptr_d  = wptr_q + DW'(push_a_i) + DW'(push_b_i);
        count_d = count_q + (DW+1)'(push_a_i) + (DW+1)'(push_b_i) - (DW+1)'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < P_DEPTH; k++) begin
                mem_q[k] <= (k < InitCount) ? DW'(P_RESERVED + k) : '0;
            end
            rptr_q  <= '0;
            wptr_q  <= DW'(InitCount);
            count_q <= (DW+1)'(InitCount);
        end else begin
            if (push_a_i) mem_q[wptr_q] <= push_a_data_i;
            if (push_b_i) mem_q[wptr_b] <= push_b_data_i;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/issue_rat_freelist_walk.sv
// Issue-stage RAT free list with per-FGR speculative acquisition tracking and an abandon walker
// that returns one PRF per cycle.
module issue_rat_freelist_walk
    import issue_rat_pkg::*;
#(
    parameter int unsigned P_PRF_COUNT    = PrfCountDef,
    parameter int unsigned P_PRF_RESERVED = PrfReservedDef,
    parameter int unsigned P_FGR_COUNT    = FgrCountDef,
    localparam int unsigned LPW           = $clog2(P_PRF_COUNT),
    localparam int unsigned LFW           = $clog2(P_FGR_COUNT)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [LPW-1:0] i_redeemed_prf,
    input  logic           i_redeemed_valid,
    output logic           o_redeemed_ready,
    output logic [LPW-1:0] o_acquire_prf,
    output logic           o_acquire_ready,
    input  logic [LFW-1:0] i_acquire_fgr,
    input  logic           i_acquire_fgr_speculative,
    input  logic           i_acquire_valid,
    input  logic [LFW-1:0] i_commit_fgr,
    input  logic           i_commit_valid,
    input  logic [LFW-1:0] i_abandon_fgr,
    input  logic           i_abandon_valid,
    output logic           o_abandon_ready,
    output logic           o_abandon_busy,
    output logic [LPW:0]   o_free_count
);

    walk_state_e          state_q, state_d;
    logic [P_PRF_COUNT-1:0] vec_q [P_FGR_COUNT];
    logic [P_PRF_COUNT-1:0] vec_d [P_FGR_COUNT];
    logic [P_PRF_COUNT-1:0] walk_q, walk_d;
    logic [P_PRF_COUNT-1:0] walk_lsb_mask;
    logic [LPW-1:0]         walk_idx;
    logic                   walk_push;
    logic                   abandon_fire, acquire_fire, redeem_fire;
    logic [LPW:0]           count;

    issue_rat_freelist_walk_fifo #(
        .P_DEPTH    (P_PRF_COUNT),
        .P_RESERVED (P_PRF_RESERVED)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .pop_i         (acquire_fire),
        .push_a_i      (redeem_fire),
        .push_a_data_i (i_redeemed_prf),
        .push_b_i      (walk_push),
        .push_b_data_i (walk_idx),
        .head_o        (o_acquire_prf),
        .count_o       (count)
    );

    assign abandon_fire     = i_abandon_valid & o_abandon_ready;
    assign o_acquire_ready  = i_acquire_valid & (count != '0) & (state_q == StIdle) & ~abandon_fire;
    assign acquire_fire     = o_acquire_ready;
    assign o_redeemed_ready = count < (LPW+1)'(P_PRF_COUNT - 1);
    assign redeem_fire      = i_redeemed_valid & o_redeemed_ready;
    assign o_free_count     = count;

    // Lowest set bit of the walk vector.
    always_comb begin
        walk_idx = '0;
        for (int i = P_PRF_COUNT - 1; i >= 0; i--) begin
            if (walk_q[i]) walk_idx = LPW'(i);
        end
        walk_lsb_mask = {{(P_PRF_COUNT-1){1'b0}}, 1'b1} << walk_idx;
    end

    always_comb begin
        walk_d = walk_q;
        if (abandon_fire) begin
            walk_d = vec_q[i_abandon_fgr];
        end else if (walk_push) begin
            walk_d = walk_q & ~walk_lsb_mask;
        end
    end

    // Later assignments win: a same-cycle speculative acquire survives a commit.
    always_comb begin
        vec_d = vec_q;
        if (i_commit_valid) vec_d[i_commit_fgr] = '0;
        if (abandon_fire) vec_d[i_abandon_fgr] = '0;
        if (acquire_fire && i_acquire_fgr_speculative) begin
            vec_d[i_acquire_fgr][o_acquire_prf] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            walk_q  <= '0;
            for (int f = 0; f < P_FGR_COUNT; f++) begin
                vec_q[f] <= '0;
            end
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (abandon_fire) state_d = StWalk;
            StWalk: if (walk_d == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_abandon_ready = (state_q == StIdle);
        o_abandon_busy  = (state_q == StWalk);
        walk_push       = (state_q == StWalk) && (walk_q != '0);
    end

endmodule
